bsrch_seq: RTL and testbench
============================

BSRCH_SEQ -- requirements
Module: bsrch_seq

Interface
REQ-001 SHALL provide parameter AW, default 4, table address width (2^AW sorted entries).
REQ-002 SHALL provide parameter DW, default 8, key/entry data width.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port start, input, 1, search request, sampled only in IDLE.
REQ-006 SHALL provide port key, input, DW, search value, latched when start is accepted.
REQ-007 SHALL provide port mem_addr, output, AW, table read address, registered.
REQ-008 SHALL provide port mem_rdata, input, DW, table read data, valid one cycle after mem_addr changes.
REQ-009 SHALL provide port busy, output, 1, high from the cycle after acceptance until done.
REQ-010 SHALL provide port done, output, 1, single-cycle completion pulse.
REQ-011 SHALL provide port found, output, 1, result flag, held until next accepted start.
REQ-012 SHALL provide port index, output, AW, result address, held until next accepted start.

Function
REQ-013 SHALL implement states IDLE, FETCH, CMP, DONE.
REQ-014 IDLE with start=1 SHALL latch key, set lo=0, hi=2^AW-1, clear found/index, go FETCH.
REQ-015 FETCH SHALL drive mid=(lo+hi)>>1, computed in AW+1 bits without overflow, on mem_addr, go CMP.
REQ-016 CMP with mem_rdata==key SHALL set found=1, index=mid, go DONE.
REQ-017 CMP with mem_rdata<key SHALL go DONE with found=0, index=mid if mid==hi, else set lo=mid+1 and go FETCH.
REQ-018 CMP with mem_rdata>key SHALL go DONE with found=0, index=mid if mid==lo, else set hi=mid-1 and go FETCH.
REQ-019 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then go IDLE.
REQ-020 Comparison SHALL be unsigned DW-bit; lo/hi SHALL never underflow or wrap.
REQ-021 Latency SHALL be 2P+1 cycles from the accepting edge to done high, P = probes, where P is at most AW+1.
REQ-022 start while busy or in DONE SHALL be ignored, with no effect on key or the result.
REQ-023 start held high continuously SHALL start a new search on the first IDLE edge after DONE.
REQ-024 mem_addr SHALL hold its last value outside FETCH.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, found=0, index=0, mem_addr=0, lo=0, hi=0.
REQ-026 rst asserted mid-search SHALL abort the search with no done pulse; start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-027 With BSRCH_PROBE_CNT_EN defined, the block SHALL add an output port probes (3 bits), cleared on accept and reset, incremented in each CMP, and held with the result.
REQ-028 Without BSRCH_PROBE_CNT_EN, the port probes and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
Table for all scenarios: mem[i]=2i+1 (1,3,...,31), AW=4, DW=8, one-cycle read model.
REQ-029 Accept key=31 at edge k -> probe addresses 7,11,13,14,15; done at k+11; found=1; index=15; probes=5.
REQ-030 Accept key=1 at edge k -> probe addresses 7,3,1,0; done at k+9; found=1; index=0.
REQ-031 Key=16 -> probe addresses 7,11,9,8; done at k+9; found=0; index=8. Key=0 -> miss with index=0. Key=255 -> miss with index=15.
REQ-032 Accept key=31, then pulse start with key=3 at k+3 -> ignored; result found=1, index=15; key=3 is not latched.
REQ-033 Accept key=31, then rst at k+4 for one cycle -> busy=0 immediately; no done pulse; outputs zero; next start key=15 -> done after 3 cycles, index=7.

Source files
------------

// File: rtl/bsrch_seq.sv
// Sequential binary search over an externally stored sorted table (one-cycle read).
// Optional probe counter output is enabled by defining BSRCH_PROBE_CNT_EN.
module bsrch_seq #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] key,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] index,
    output logic [1:0]    state_dbg
`ifdef BSRCH_PROBE_CNT_EN
    ,
    output logic [2:0]    probes
`endif
);

    // Handshake: start is sampled only in IDLE; the accepting edge raises busy,
    // busy stays high until the edge that raises done, and done is a one-cycle
    // pulse with found/index already stable and held until the next accept.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CMP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] key_q;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW:0]   mid_sum;
    logic [AW-1:0] mid;

    // One extra bit keeps lo+hi exact before halving.
    assign mid_sum   = {1'b0, lo} + {1'b0, hi};
    assign mid       = AW'(mid_sum >> 1);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            key_q    <= '0;
            lo       <= '0;
            hi       <= '0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            index    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q <= key;
                        lo    <= '0;
                        hi    <= '1;
                        found <= 1'b0;
                        index <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_addr <= mid;
                    state    <= S_CMP;
                end
                S_CMP: begin
                    // mem_addr still holds the probed mid while its data is compared.
                    if (mem_rdata == key_q) begin
                        found <= 1'b1;
                        index <= mem_addr;
                        state <= S_DONE;
                    end else if (mem_rdata < key_q) begin
                        if (mem_addr == hi) begin
                            index <= mem_addr;
                            state <= S_DONE;
                        end else begin
                            lo    <= mem_addr + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        if (mem_addr == lo) begin
                            index <= mem_addr;
                            state <= S_DONE;
                        end else begin
                            hi    <= mem_addr - 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BSRCH_PROBE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probes <= '0;
        end else if (state == S_IDLE && start) begin
            probes <= '0;
        end else if (state == S_CMP) begin
            probes <= probes + 3'd1;
        end
    end
`endif

    a_done_not_busy : assert property (@(posedge clk) disable iff (rst) done |-> !busy);
    a_window_order  : assert property (@(posedge clk) disable iff (rst) (state == S_FETCH) |-> (lo <= hi));

endmodule

// File: tb/tb_bsrch_seq.sv
// Self-checking bench for bsrch_seq: directed table vectors, random keys and
// tables against a loop-based search model, ignored start, mid-search reset, held start.
module tb_bsrch_seq;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] key;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] index;
  logic [1:0]    state_dbg;
  logic [2:0]    probes_v;

  logic [DW-1:0] mem [N];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

`ifdef BSRCH_PROBE_CNT_EN
  logic [2:0] probes;
  assign probes_v = probes;
`else
  assign probes_v = 3'd0;
`endif

  bsrch_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .found(found), .index(index),
    .state_dbg(state_dbg)
`ifdef BSRCH_PROBE_CNT_EN
    , .probes(probes)
`endif
  );

  // clock / reset block and one-cycle read table
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr];

  task automatic load_odd_table();
    for (int i = 0; i < N; i++) mem[i] = 8'(2 * i + 1);
  endtask

  task automatic load_random_table();
    mem[0] = 8'($urandom_range(0, 15));
    for (int i = 1; i < N; i++) mem[i] = mem[i-1] + 8'($urandom_range(0, 15));
  endtask

  // reference model: textbook halving of an integer window over the table
  task automatic model_search(input logic [DW-1:0] k, output bit f, output logic [AW-1:0] idx);
    int lo, hi, mid;
    lo = 0; hi = N - 1; f = 0; idx = '0;
    exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      mid = (lo + hi) / 2;
      exp_q.push_back(AW'(mid));
      if (mem[mid] == k) begin f = 1; idx = AW'(mid); break; end
      if (mem[mid] < k) begin
        if (mid == hi) begin idx = AW'(mid); break; end
        lo = mid + 1;
      end else begin
        if (mid == lo) begin idx = AW'(mid); break; end
        hi = mid - 1;
      end
    end
  endtask

  function automatic bit seq_ok();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  // driver tasks
  task automatic drive_accept(input logic [DW-1:0] k, output int k_edge);
    @(negedge clk);
    start = 1'b1; key = k;
    @(negedge clk);
    k_edge = cyc;
    start = 1'b0; key = 8'($urandom_range(0, 255));
  endtask

  task automatic collect_result(input int k_edge, input bit poke, output int lat, output bit f,
                                output logic [AW-1:0] idx, output bit busy_ok, output logic [2:0] pc);
    int off;
    lat = -1; f = 0; idx = '0; pc = '0; busy_ok = 1;
    got_q.delete();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      off = cyc - k_edge;
      if (poke && off == 2) begin start = 1'b1; key = 8'd3; end
      if (poke && off == 3) start = 1'b0;
      if (done) begin
        lat = off; f = found; idx = index; pc = probes_v;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
      if (off % 2 == 1) got_q.push_back(mem_addr);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || index !== '0 || mem_addr !== '0 || probes_v !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b index=%0d addr=%0d probes=%0d required all zero",
               busy, done, found, index, mem_addr, probes_v);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic run_and_check(input string name, input logic [DW-1:0] k);
    int k_edge, lat;
    bit f, ef, bok;
    logic [AW-1:0] idx, eidx;
    logic [2:0] pc;
    model_search(k, ef, eidx);
    drive_accept(k, k_edge);
    collect_result(k_edge, 1'b0, lat, f, idx, bok, pc);
    n_checks++;
    if (lat !== 2 * exp_q.size() + 1) begin
      n_fail++; $display("FAIL %s_latency key=%0d: got %0d required %0d", name, k, lat, 2 * exp_q.size() + 1);
    end
    n_checks++;
    if (f !== ef || idx !== eidx) begin
      n_fail++; $display("FAIL %s_result key=%0d: got found=%b index=%0d required found=%b index=%0d", name, k, f, idx, ef, eidx);
    end
    n_checks++;
    if (!seq_ok()) begin
      n_fail++; $display("FAIL %s_probe_addrs key=%0d: got %0d probes required %0d", name, k, got_q.size(), exp_q.size());
    end
    n_checks++;
    if (!bok) begin
      n_fail++; $display("FAIL %s_busy key=%0d: busy wrong during search, required high until done", name, k);
    end
`ifdef BSRCH_PROBE_CNT_EN
    n_checks++;
    if (pc !== 3'(exp_q.size())) begin
      n_fail++; $display("FAIL %s_probe_count key=%0d: got %0d required %0d", name, k, pc, exp_q.size());
    end
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || found !== ef || index !== eidx) begin
      n_fail++; $display("FAIL %s_hold key=%0d: got done=%b found=%b index=%0d required 0 %b %0d", name, k, done, found, index, ef, eidx);
    end
  endtask

  task automatic test_table_vectors();
    load_odd_table();
    run_and_check("hit_top", 8'd31);
    run_and_check("hit_bottom", 8'd1);
    run_and_check("miss_mid", 8'd16);
    run_and_check("miss_low", 8'd0);
    run_and_check("miss_high", 8'd255);
    run_and_check("hit_first_probe", 8'd15);
  endtask

  task automatic test_random();
    load_odd_table();
    for (int i = 0; i < 16; i++) run_and_check("rand_key", 8'($urandom_range(0, 255)));
    for (int t = 0; t < 3; t++) begin
      load_random_table();
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) run_and_check("rand_tbl_hit", mem[$urandom_range(0, N - 1)]);
        else run_and_check("rand_tbl_key", 8'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic test_ignore_start();
    int k_edge, lat;
    bit f, bok;
    logic [AW-1:0] idx;
    logic [2:0] pc;
    load_odd_table();
    drive_accept(8'd31, k_edge);
    collect_result(k_edge, 1'b1, lat, f, idx, bok, pc);
    n_checks++;
    if (lat !== 11 || f !== 1'b1 || idx !== 4'd15) begin
      n_fail++; $display("FAIL ignore_start: got lat=%0d found=%b index=%0d required 11 1 15", lat, f, idx);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_search();
    int k_edge, lat;
    bit f, bok, saw_done, saw_busy;
    logic [AW-1:0] idx;
    logic [2:0] pc;
    load_odd_table();
    drive_accept(8'd31, k_edge);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || index !== '0 || mem_addr !== '0 || probes_v !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b found=%b index=%0d addr=%0d probes=%0d required all zero",
               busy, done, found, index, mem_addr, probes_v);
    end
    @(negedge clk); rst = 1'b0;
    saw_done = 0; saw_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    n_checks++;
    if (saw_done || saw_busy) begin
      n_fail++; $display("FAIL abort_no_done: got done_seen=%b busy_seen=%b required 0 0", saw_done, saw_busy);
    end
    drive_accept(8'd15, k_edge);
    collect_result(k_edge, 1'b0, lat, f, idx, bok, pc);
    n_checks++;
    if (lat !== 3 || f !== 1'b1 || idx !== 4'd7) begin
      n_fail++; $display("FAIL after_abort: got lat=%0d found=%b index=%0d required 3 1 7", lat, f, idx);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k_edge, lat;
    bit f, ef, bok;
    logic [AW-1:0] idx, eidx;
    logic [2:0] pc;
    load_odd_table();
    model_search(8'd5, ef, eidx);
    @(negedge clk);
    start = 1'b1; key = 8'd5;
    @(negedge clk);
    k_edge = cyc;
    collect_result(k_edge, 1'b0, lat, f, idx, bok, pc);
    n_checks++;
    if (lat !== 2 * exp_q.size() + 1 || f !== ef || idx !== eidx) begin
      n_fail++; $display("FAIL held_first: got lat=%0d found=%b index=%0d required %0d %b %0d", lat, f, idx, 2 * exp_q.size() + 1, ef, eidx);
    end
    @(negedge clk);
    k_edge = cyc;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL held_reaccept: got busy=%b done=%b required 1 0", busy, done);
    end
    collect_result(k_edge, 1'b0, lat, f, idx, bok, pc);
    n_checks++;
    if (lat !== 2 * exp_q.size() + 1 || f !== ef || idx !== eidx || !seq_ok()) begin
      n_fail++; $display("FAIL held_second: got lat=%0d found=%b index=%0d required %0d %b %0d", lat, f, idx, 2 * exp_q.size() + 1, ef, eidx);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0;
    load_odd_table();
    repeat (2) @(negedge clk);
    test_reset();
    test_table_vectors();
    test_random();
    test_ignore_start();
    test_reset_mid_search();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
